// File: rtl/image_load_sequencer_pkg.sv
// Shared types and sizing for the SD-to-frame-RAM image load path.
package image_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    STREAM,
    RETRY,
    NEXT,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_SECTOR = 512;
  localparam int WORDS_PER_SECTOR = 256;
  localparam int RAM_AW           = 17;

endpackage

// File: rtl/image_load_sequencer_byte_word_packer.sv
// Pairs incoming bytes into big-endian 16-bit words and issues one RAM write per pair.
module byte_word_packer
  import image_load_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [RAM_AW-1:0] clear_addr,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic              ram_we,
  output logic [15:0]       ram_data,
  output logic [RAM_AW-1:0] ram_addr
);

  logic              odd;
  logic [7:0]        hi;
  logic [RAM_AW-1:0] word_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      odd       <= 1'b0;
      hi        <= '0;
      word_addr <= '0;
      ram_we    <= 1'b0;
      ram_data  <= '0;
      ram_addr  <= '0;
    end else begin
      ram_we <= 1'b0;
      if (clear) begin
        // Restart pairing at an even byte and rewind to the sector's first word.
        odd       <= 1'b0;
        word_addr <= clear_addr;
      end else if (byte_en) begin
        if (!odd) begin
          hi <= byte_data;
        end else begin
          ram_we    <= 1'b1;
          ram_data  <= {hi, byte_data};
          ram_addr  <= word_addr;
          word_addr <= word_addr + RAM_AW'(1);
        end
        odd <= ~odd;
      end
    end
  end

endmodule

// File: rtl/image_load_sequencer.sv
// Fetches one image slot from SD, one sector per read command, into frame RAM Port A
// with per-sector retries and done/error status.
module image_load_sequencer
  import image_load_pkg::*;
#(
  parameter int unsigned BASE_SECTOR       = 0,
  parameter int unsigned SECTORS_PER_IMAGE = 300,
  parameter int unsigned MAX_RETRY         = 3,
  parameter int unsigned WAIT_TIMEOUT      = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [1:0]        image_select,
  input  logic              sd_busy,
  input  logic              sd_error,
  input  logic [7:0]        sd_data,
  input  logic              sd_data_valid,
  output logic              sd_start_read,
  output logic [31:0]       sd_sector_addr,
  output logic [7:0]        sd_block_count,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_data,
  output logic              ram_we,
  output logic              loading,
  output logic              load_done,
  output logic              load_error
);

  localparam int SW = $clog2(SECTORS_PER_IMAGE + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);

  state_t            state;
  logic [SW-1:0]     sector_idx;
  logic [RW-1:0]     retry_cnt;
  logic [TW-1:0]     tcnt;
  logic [9:0]        byte_cnt;
  logic              fail;

  logic              accept;
  logic              byte_en;
  logic [9:0]        byte_cnt_nxt;
  logic              pack_clear;
  logic [RAM_AW-1:0] rewind_addr;

  assign sd_block_count = 8'd1;

  assign accept       = load_req && (state == IDLE || state == DONE || state == ERR);
  assign byte_en      = (state == STREAM) && sd_data_valid &&
                        (byte_cnt < 10'(BYTES_PER_SECTOR));
  // Includes a byte arriving in the same cycle that busy falls.
  assign byte_cnt_nxt = byte_cnt + 10'(byte_en);
  assign pack_clear   = accept || (state == RETRY);
  assign rewind_addr  = accept ? '0 :
                        RAM_AW'(sector_idx) * RAM_AW'(WORDS_PER_SECTOR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      sector_idx     <= '0;
      retry_cnt      <= '0;
      tcnt           <= '0;
      byte_cnt       <= '0;
      fail           <= 1'b0;
      sd_start_read  <= 1'b0;
      sd_sector_addr <= '0;
      loading        <= 1'b0;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      sd_start_read <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (load_req) begin
            sector_idx     <= '0;
            retry_cnt      <= '0;
            byte_cnt       <= '0;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
            loading        <= 1'b1;
            sd_start_read  <= 1'b1;
            sd_sector_addr <= BASE_SECTOR + 32'(image_select) * SECTORS_PER_IMAGE;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt     <= '0;
          byte_cnt <= '0;
          fail     <= 1'b0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (sd_busy)                       state <= STREAM;
          else if (tcnt == TW'(WAIT_TIMEOUT)) state <= RETRY;
          else                               tcnt  <= tcnt + TW'(1);
        end
        STREAM: begin
          byte_cnt <= byte_cnt_nxt;
          if (sd_error) fail <= 1'b1;
          if (!sd_busy)
            state <= (byte_cnt_nxt == 10'(BYTES_PER_SECTOR) && !fail && !sd_error) ?
                     NEXT : RETRY;
        end
        RETRY: begin
          byte_cnt  <= '0;
          retry_cnt <= retry_cnt + RW'(1);
          if (retry_cnt == RW'(MAX_RETRY - 1)) begin
            loading    <= 1'b0;
            load_error <= 1'b1;
            state      <= ERR;
          end else begin
            sd_start_read <= 1'b1;
            state         <= ISSUE;
          end
        end
        NEXT: begin
          retry_cnt  <= '0;
          sector_idx <= sector_idx + SW'(1);
          if (sector_idx == SW'(SECTORS_PER_IMAGE - 1)) begin
            loading   <= 1'b0;
            load_done <= 1'b1;
            state     <= DONE;
          end else begin
            sd_start_read  <= 1'b1;
            sd_sector_addr <= sd_sector_addr + 32'd1;
            state          <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear),
    .clear_addr (rewind_addr),
    .byte_en    (byte_en),
    .byte_data  (sd_data),
    .ram_we     (ram_we),
    .ram_data   (ram_data),
    .ram_addr   (ram_addr)
  );

endmodule

// File: tb/tb_image_load_sequencer.sv
// Scoreboarded bench: an SD reader model drives per-attempt behaviours; monitors check issued sectors and RAM writes.
module tb_image_load_sequencer;

  localparam int unsigned BASE = 100;
  localparam int unsigned SPI  = 6;
  localparam int unsigned MAXR = 3;
  localparam int unsigned WTO  = 40;

  // Reader behaviours per attempt.
  localparam int B_GOOD = 0, B_SHORT = 1, B_ERR = 2, B_NOBUSY = 3;

  logic        clk = 1'b0;
  logic        rst_n, load_req, sd_busy, sd_error, sd_data_valid;
  logic [1:0]  image_select;
  logic [7:0]  sd_data;
  logic        sd_start_read, ram_we, loading, load_done, load_error;
  logic [31:0] sd_sector_addr;
  logic [7:0]  sd_block_count;
  logic [16:0] ram_addr;
  logic [15:0] ram_data;

  always #5 clk = ~clk;

  image_load_sequencer #(
    .BASE_SECTOR(BASE), .SECTORS_PER_IMAGE(SPI), .MAX_RETRY(MAXR), .WAIT_TIMEOUT(WTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .image_select(image_select),
    .sd_busy(sd_busy), .sd_error(sd_error), .sd_data(sd_data), .sd_data_valid(sd_data_valid),
    .sd_start_read(sd_start_read), .sd_sector_addr(sd_sector_addr),
    .sd_block_count(sd_block_count), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_we(ram_we), .loading(loading), .load_done(load_done), .load_error(load_error)
  );

  typedef struct { int addr; logic [15:0] data; } wr_t;

  wr_t wr_q[$];
  int  iss_q[$];
  int  beh_q[$];
  int  checks = 0, errors = 0;
  int  cur_base = 0;
  int  last_wr_addr = -1;
  int  wr_count = 0;
  bit  pattern = 1'b0;
  bit  abort = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic quiet();
    sd_busy = 1'b0; sd_data_valid = 1'b0; sd_error = 1'b0; sd_data = 8'h00;
  endtask

  // One SD read attempt as seen by the reader model; expected RAM writes follow from
  // the sector's position within the slot and the byte order.
  task automatic attempt(input int beh, input int sec);
    int n;
    bit fall_same;
    logic [7:0] b, hi;
    wr_t w;
    if (beh == B_NOBUSY) return;
    n = (beh == B_SHORT) ? 510 : 512;
    fall_same = (beh == B_GOOD) && ($urandom_range(0, 1) == 1);
    hi = 8'h00;
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      if (abort) begin quiet(); return; end
    end
    sd_busy = 1'b1;
    @(negedge clk);
    if (abort) begin quiet(); return; end
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        sd_data_valid = 1'b0; sd_error = 1'b0;
        @(negedge clk);
        if (abort) begin quiet(); return; end
      end
      b = pattern ? 8'(i) : 8'($urandom);
      sd_data = b; sd_data_valid = 1'b1;
      sd_error = (beh == B_ERR) && (i == 100);
      if (fall_same && i == n - 1) sd_busy = 1'b0;
      if (i % 2 == 0) hi = b;
      else begin
        w.addr = (sec - cur_base) * 256 + i / 2;
        w.data = {hi, b};
        wr_q.push_back(w);
      end
      @(negedge clk);
      if (abort) begin quiet(); return; end
    end
    quiet();
  endtask

  // Reader model
  initial begin
    int beh;
    quiet();
    forever begin
      @(negedge clk);
      if (sd_start_read && !abort) begin
        beh = (beh_q.size() > 0) ? beh_q.pop_front() : B_NOBUSY;
        attempt(beh, int'(sd_sector_addr));
      end
    end
  end

  // Issue monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && sd_start_read) begin
        if (iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected: got sector %0d, none expected", sd_sector_addr);
        end else begin
          chk("issue_sector", sd_sector_addr, iss_q.pop_front());
          chk("block_count", 32'(sd_block_count), 1);
        end
      end
    end
  end

  // Write monitor
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (ram_we) begin
        wr_count++;
        last_wr_addr = int'(ram_addr);
        chk("ram_addr_range", 32'(ram_addr <= 17'(SPI * 256 - 1)), 1);
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL write_unexpected: got addr %0d data 0x%0h, none expected", ram_addr, ram_data);
        end else begin
          w = wr_q.pop_front();
          chk("ram_addr", 32'(ram_addr), w.addr);
          chk("ram_data", 32'(ram_data), 32'(w.data));
        end
      end
    end
  end

  task automatic set_slot(input int sel);
    cur_base = BASE + sel * SPI;
  endtask

  task automatic plan(input int s, input int beh);
    iss_q.push_back(cur_base + s);
    beh_q.push_back(beh);
  endtask

  task automatic plan_all_good(input int from);
    for (int s = from; s < SPI; s++) plan(s, B_GOOD);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(load_done || load_error) && n < 12000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 12000) begin
      errors++;
      $display("FAIL load_end_timeout: got no done/error within %0d cycles, required one", n);
    end
  endtask

  task automatic pulse_load(input int sel);
    @(negedge clk);
    image_select = 2'(sel);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic go(input int sel, input bit exp_ok, input bit poke);
    pulse_load(sel);
    chk("accept_loading", 32'(loading), 1);
    chk("accept_done_clr", 32'(load_done), 0);
    chk("accept_err_clr", 32'(load_error), 0);
    if (poke) begin
      repeat (700) @(negedge clk);
      image_select = 2'(sel + 1);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      chk("poke_still_loading", 32'(loading), 1);
    end
    wait_end();
    repeat (2) @(negedge clk);
    chk("end_done", 32'(load_done), 32'(exp_ok));
    chk("end_error", 32'(load_error), 32'(!exp_ok));
    chk("end_loading", 32'(loading), 0);
    chk("issues_consumed", iss_q.size(), 0);
    chk("writes_consumed", wr_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start_read"}, 32'(sd_start_read), 0);
    chk({tag, "_sector_addr"}, sd_sector_addr, 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_data"}, 32'(ram_data), 0);
    chk({tag, "_loading"}, 32'(loading), 0);
    chk({tag, "_load_done"}, 32'(load_done), 0);
    chk({tag, "_load_error"}, 32'(load_error), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; load_req = 1'b0; image_select = 2'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_block_count", 32'(sd_block_count), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Counting byte pattern, slot 2, with an ignored mid-load request and select change.
    pattern = 1'b1;
    set_slot(2); plan_all_good(0);
    go(2, 1'b1, 1'b1);
    chk("last_write_addr", last_wr_addr, SPI * 256 - 1);
    pattern = 1'b0;

    // Last sector comes back two bytes short once.
    set_slot(0);
    for (int s = 0; s < SPI - 1; s++) plan(s, B_GOOD);
    plan(SPI - 1, B_SHORT); plan(SPI - 1, B_GOOD);
    go(0, 1'b1, 1'b0);

    // Sector 0 reports an error on every attempt.
    set_slot(0);
    for (int k = 0; k < MAXR; k++) plan(0, B_ERR);
    go(0, 1'b0, 1'b0);

    // Reader never goes busy.
    set_slot(3);
    for (int k = 0; k < MAXR; k++) plan(0, B_NOBUSY);
    go(3, 1'b0, 1'b0);

    // Mixed failures below the limit on different sectors still complete.
    set_slot(1);
    plan(0, B_GOOD); plan(1, B_GOOD);
    plan(2, B_NOBUSY); plan(2, B_SHORT); plan(2, B_GOOD);
    plan(3, B_GOOD);
    plan(4, B_ERR); plan(4, B_GOOD);
    plan(5, B_GOOD);
    go(1, 1'b1, 1'b0);

    // Reset in the middle of a stream, then a clean reload.
    set_slot(2); plan_all_good(0);
    pulse_load(2);
    wr_count = 0; n = 0;
    while (wr_count < 40 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("stream_reached", 32'(wr_count >= 40), 1);
    abort = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    iss_q.delete(); beh_q.delete(); wr_q.delete();
    abort = 1'b0;
    set_slot(2); plan_all_good(0);
    go(2, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_load_sequencer.md
Name: image_load_sequencer

Overview:
- Sequences the SD card reader to fetch one full RGB444 frame from SD into the dual-port frame RAM, one sector per command.
- Sits between sd_card_reader (command/byte-stream side) and the frame RAM write port (Port A), replacing the free-running start_read tie-off.
- Packs the byte stream into 16-bit words, tracks sector progress, retries failed sectors and reports done/error status to top-level control.

Parameters:
- BASE_SECTOR, 0, first SD sector of image slot 0.
- SECTORS_PER_IMAGE, 300, sectors per image slot (320x240 words x 2 B = 153600 B).
- MAX_RETRY, 3, attempts per sector before declaring error.
- WAIT_TIMEOUT, 65535, cycles allowed in WAIT_BUSY for sd_busy to rise.

Ports:
- clk  in  1  system clock, 25 MHz domain.
- rst_n  in  1  reset, synchronous, active-low.
- load_req  in  1  single-cycle pulse: start a load of image_select.
- image_select  in  2  image slot to load; sampled only on an accepted load_req.
- sd_busy  in  1  reader busy.
- sd_error  in  1  reader error flag.
- sd_data  in  8  reader byte.
- sd_data_valid  in  1  sd_data qualifier.
- sd_start_read  out  1  single-cycle command pulse.
- sd_sector_addr  out  32  sector to read; held stable from ISSUE until the next ISSUE.
- sd_block_count  out  8  constant 1.
- ram_addr  out  17  frame RAM word address.
- ram_data  out  16  packed word; first byte in [15:8], second byte in [7:0].
- ram_we  out  1  RAM write strobe.
- loading  out  1  high while a load is in progress.
- load_done  out  1  level, high after the last sector is written.
- load_error  out  1  level, high after retry exhaustion.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; every output and counter is 0. Applies mid-load: ram_we drops on that edge and the partial frame is abandoned.
- IDLE:
  - load_req latches sel, then clears sector_idx, word_addr, retry_cnt and the byte counter, and goes to ISSUE.
  - load_done and load_error clear on acceptance.
- ISSUE (1 cycle):
  - sd_start_read=1.
  - sd_sector_addr = BASE_SECTOR + sel*SECTORS_PER_IMAGE + sector_idx (32-bit unsigned).
  - The multiply is computed once at latch time.
  - Next state: WAIT_BUSY; timeout counter cleared.
- WAIT_BUSY:
  - sd_busy=1 goes to STREAM.
  - If the timeout counter reaches WAIT_TIMEOUT, treat as a failed attempt (see RETRY).
- STREAM:
  - On each sd_data_valid, byte_cnt increments (10-bit).
  - Even byte: latch into hi register.
  - Odd byte: on the next edge, ram_we=1, ram_data={hi,sd_data}, ram_addr=word_addr; word_addr then increments. Write latency is 1 cycle after the odd byte.
  - Bytes beyond 512 are ignored (no write).
  - sd_error=1 at any cycle sets a sticky fail flag.
  - On sd_busy falling: if byte_cnt==512 and no fail, go to NEXT; otherwise go to RETRY.
- RETRY:
  - retry_cnt++; word_addr rewinds to sector_idx*256; byte_cnt clears.
  - If retry_cnt reaches MAX_RETRY, go to ERR; else go to ISSUE.
- NEXT:
  - retry_cnt=0; sector_idx++.
  - If the new sector_idx == SECTORS_PER_IMAGE, go to DONE; else go to ISSUE.
- DONE: load_done=1, loading=0. A new load_req restarts as from IDLE.
- ERR: load_error=1, loading=0. A new load_req restarts.
- loading=1 in ISSUE, WAIT_BUSY, STREAM, RETRY and NEXT.
- load_req while loading is ignored.
- image_select changes while loading have no effect.
- sd_data_valid outside STREAM is ignored.
- Odd byte and busy-fall in the same cycle: the byte is counted and written first, and the 512 check includes it.
- ram_addr never exceeds SECTORS_PER_IMAGE*256-1.

Decomposition:
- Package image_load_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_BUSY, STREAM, RETRY, NEXT, DONE, ERR);
  - BYTES_PER_SECTOR=512 and WORDS_PER_SECTOR=256;
  - the RAM address width of 17.
- One sub-module, byte_word_packer: byte-to-16-bit pairing plus write strobe, with a clear input used on RETRY and on load start.

Test Plan:
- Reset then load_req with image_select=2, model returns 512 bytes 0x00..0xFF twice per sector → first sd_sector_addr=600; word 0 = 0x0001 at addr 0; after 300 sectors load_done=1, last write at addr 76799.
- Sector 5 returns only 510 bytes before busy falls → RETRY, reissue of sector 5, ram_addr restarts at 1280; load completes with correct data.
- Model asserts sd_error on every attempt of sector 0 → 3 ISSUE pulses, then load_error=1, loading=0, no load_done.
- Model never raises sd_busy → WAIT_TIMEOUT expiry counts as an attempt; after 3 timeouts load_error=1.
- load_req pulsed mid-load and image_select toggled → both ignored; sd_sector_addr stays on the original slot.
- rst_n low for 1 cycle during STREAM → all outputs 0 at the next edge; a subsequent load_req restarts at sector BASE_SECTOR + sel*300 and ram_addr 0.
